// File: rtl/ifmap_diag_feeder_if.sv
// Valid/ready ifmap beat stream into the diagonal feeder: five PE_WIDTH lanes per beat,
// lane00 in the most-significant slice.
interface ifmap_diag_feeder_if #(
  parameter int unsigned PE_WIDTH = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic [5*PE_WIDTH-1:0]   s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ifmap_diag_feeder.sv
// Drives the 3x3 PE array's five diagonal ifmap inputs at a fixed cadence, drains the array
// at frame end and flags psum_valid in line with the bottom-row psums. Option: FEEDER_STALL_CNT_EN.
module ifmap_diag_feeder #(
  parameter int unsigned PE_WIDTH     = 4,
  parameter int unsigned DELAY_CYCLES = 10,
  parameter int unsigned ISSUE_GAP    = 1,
  parameter int unsigned LEN_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    cfg_frame_len,
  ifmap_diag_feeder_if.slave  s_if,
  output logic [PE_WIDTH-1:0] ifmap_IN_00,
  output logic [PE_WIDTH-1:0] ifmap_IN_01,
  output logic [PE_WIDTH-1:0] ifmap_IN_02,
  output logic [PE_WIDTH-1:0] ifmap_IN_10,
  output logic [PE_WIDTH-1:0] ifmap_IN_20,
  output logic                psum_valid,
  output logic                busy,
  output logic                frame_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int unsigned PIPE  = 3 * DELAY_CYCLES;
  localparam int unsigned GAP_W = (ISSUE_GAP < 2) ? 1 : $clog2(ISSUE_GAP + 1);
  localparam int unsigned DRN_W = $clog2(PIPE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [LEN_W-1:0]      r_len_q;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [DRN_W-1:0]      r_drain_cnt;
  logic [5*PE_WIDTH-1:0] r_lanes;
  logic                  r_issue;
  logic [PIPE-1:0]       r_psum_sr;
  logic                  r_busy;
  logic                  r_frame_done;

  logic                  w_hs;
  logic [LEN_W-1:0]      w_beat_nxt;
  logic                  w_last_beat;

  assign s_if.s_ready = (r_state == S_ISSUE);
  assign w_hs         = s_if.s_valid & s_if.s_ready;
  assign w_beat_nxt   = r_beat_cnt + LEN_W'(1);
  assign w_last_beat  = (r_beat_cnt == r_len_q);

  // HOLD covers the first ISSUE_GAP-1 cycles of a beat; its last cycle is spent back in ISSUE
  // so the next beat can land without a bubble. The final beat instead stays the full gap in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_len_q      <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_drain_cnt  <= '0;
      r_lanes      <= '0;
      r_issue      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_issue      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_lanes <= '0;
          if (start) begin
            r_len_q    <= cfg_frame_len;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            if (cfg_frame_len == '0) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_hs) begin
            r_lanes    <= s_if.s_data;
            r_beat_cnt <= w_beat_nxt;
            r_issue    <= 1'b1;
            if (ISSUE_GAP == 1) begin
              if (w_beat_nxt == r_len_q) begin
                r_state     <= S_DRAIN;
                r_drain_cnt <= '0;
              end
            end else begin
              r_state   <= S_HOLD;
              r_gap_cnt <= GAP_W'(1);
            end
          end else begin
            r_lanes <= '0;
          end
        end
        S_HOLD: begin
          if (w_last_beat) begin
            if (r_gap_cnt == GAP_W'(ISSUE_GAP)) begin
              r_state     <= S_DRAIN;
              r_lanes     <= '0;
              r_drain_cnt <= DRN_W'(1);
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end else if (r_gap_cnt == GAP_W'(ISSUE_GAP - 1)) begin
            r_state <= S_ISSUE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        S_DRAIN: begin
          // Entry from ISSUE still shows the last beat for one cycle, so the count starts at 0.
          r_lanes <= '0;
          if (r_drain_cnt == DRN_W'(PIPE)) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_lanes <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_lanes <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psum_sr <= '0;
    end else begin
      r_psum_sr <= {r_psum_sr[PIPE-2:0], r_issue};
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ISSUE) && !s_if.s_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign ifmap_IN_00 = r_lanes[5*PE_WIDTH-1 -: PE_WIDTH];
  assign ifmap_IN_01 = r_lanes[4*PE_WIDTH-1 -: PE_WIDTH];
  assign ifmap_IN_02 = r_lanes[3*PE_WIDTH-1 -: PE_WIDTH];
  assign ifmap_IN_10 = r_lanes[2*PE_WIDTH-1 -: PE_WIDTH];
  assign ifmap_IN_20 = r_lanes[PE_WIDTH-1:0];
  assign psum_valid  = r_psum_sr[PIPE-1];
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_ifmap_diag_feeder.sv
// Directed bench for ifmap_diag_feeder: one instance at ISSUE_GAP=1, one at ISSUE_GAP=3,
// both with DELAY_CYCLES=2 (6-cycle array depth).
`timescale 1ns/1ps
module tb_ifmap_diag_feeder;
  localparam int unsigned PW = 4;
  localparam int unsigned DC = 2;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start1, start3;
  logic [LW-1:0] len1, len3;
  logic [PW-1:0] a00, a01, a02, a10, a20;
  logic [PW-1:0] b00, b01, b02, b10, b20;
  logic          psum1, busy1, fd1, psum3, busy3, fd3;
  logic [19:0]   lanes1, lanes3;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]   stall1, stall3;
`endif

  ifmap_diag_feeder_if #(.PE_WIDTH(PW)) if1 ();
  ifmap_diag_feeder_if #(.PE_WIDTH(PW)) if3 ();

  ifmap_diag_feeder #(.PE_WIDTH(PW), .DELAY_CYCLES(DC), .ISSUE_GAP(1), .LEN_W(LW)) u1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_frame_len(len1), .s_if(if1.slave),
    .ifmap_IN_00(a00), .ifmap_IN_01(a01), .ifmap_IN_02(a02), .ifmap_IN_10(a10), .ifmap_IN_20(a20),
    .psum_valid(psum1), .busy(busy1), .frame_done(fd1)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  ifmap_diag_feeder #(.PE_WIDTH(PW), .DELAY_CYCLES(DC), .ISSUE_GAP(3), .LEN_W(LW)) u3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_frame_len(len3), .s_if(if3.slave),
    .ifmap_IN_00(b00), .ifmap_IN_01(b01), .ifmap_IN_02(b02), .ifmap_IN_10(b10), .ifmap_IN_20(b20),
    .psum_valid(psum3), .busy(busy3), .frame_done(fd3)
`ifdef FEEDER_STALL_CNT_EN
    , .stall_cnt(stall3)
`endif
  );

  assign lanes1 = {a00, a01, a02, a10, a20};
  assign lanes3 = {b00, b01, b02, b10, b20};

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [19:0] d1 [0:2];
  logic [19:0] d3 [0:2];
  logic [19:0] cap [0:15];
  logic [15:0] pv, fdv, bzv, rdv, lnz;
  logic        acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame on instance sel (1 or 3), then runs 16 cycles; bit i of each vector is
  // sampled just after the (i+1)-th edge following the start edge.
  task automatic run_frame(input int unsigned sel, input logic [LW-1:0] len,
                           input logic [15:0] vpat, input logic [15:0] spat);
    int unsigned beat;
    beat = 0;
    pv = '0; fdv = '0; bzv = '0; rdv = '0; lnz = '0;
    if (sel == 1) begin start1 = 1'b1; len1 = len; end
    else          begin start3 = 1'b1; len3 = len; end
    step();
    start1 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sel == 1) begin
        if1.s_valid = vpat[i];
        if1.s_data  = d1[(beat > 2) ? 2 : beat];
        start1      = spat[i];
        if (spat[i]) len1 = 8'd5;
        if (vpat[i] && if1.s_ready) beat++;
      end else begin
        if3.s_valid = vpat[i];
        if3.s_data  = d3[(beat > 2) ? 2 : beat];
        start3      = spat[i];
        if (spat[i]) len3 = 8'd5;
        if (vpat[i] && if3.s_ready) beat++;
      end
      step();
      if (sel == 1) begin
        pv[i] = psum1; fdv[i] = fd1; bzv[i] = busy1; rdv[i] = if1.s_ready;
        lnz[i] = (lanes1 != '0); cap[i] = lanes1;
      end else begin
        pv[i] = psum3; fdv[i] = fd3; bzv[i] = busy3; rdv[i] = if3.s_ready;
        lnz[i] = (lanes3 != '0); cap[i] = lanes3;
      end
    end
    if1.s_valid = 1'b0; if3.s_valid = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start1 = 1'b0; start3 = 1'b0; len1 = '0; len3 = '0;
    if1.s_valid = 1'b0; if1.s_data = '0;
    if3.s_valid = 1'b0; if3.s_data = '0;
    step(); step();
    chk("rst_lanes", {12'h0, lanes1}, 32'h0);
    chk("rst_ready", {31'h0, if1.s_ready}, 32'h0);
    chk("rst_busy",  {31'h0, busy1}, 32'h0);
    chk("rst_psum",  {31'h0, psum1}, 32'h0);
    chk("rst_done",  {31'h0, fd1}, 32'h0);
    rst = 1'b1;
    step();

    // Back-to-back frame of three beats with s_valid held
    d1[0] = 20'h12345; d1[1] = 20'h6789A; d1[2] = 20'hBCDEF;
    run_frame(1, 8'd3, 16'h0007, 16'h0000);
    chk("A_in00",  {28'h0, cap[0][19:16]}, 32'h1);
    chk("A_in20",  {28'h0, cap[0][3:0]}, 32'h5);
    chk("A_beat2", {12'h0, cap[1]}, 32'h6789A);
    chk("A_beat3", {12'h0, cap[2]}, 32'hBCDEF);
    chk("A_lanes", {16'h0, lnz}, 32'h0007);
    chk("A_ready", {16'h0, rdv}, 32'h0003);
    chk("A_psum",  {16'h0, pv},  32'h01C0);
    chk("A_done",  {16'h0, fdv}, 32'h0200);
    chk("A_busy",  {16'h0, bzv}, 32'h03FF);
`ifdef FEEDER_STALL_CNT_EN
    chk("A_stall", {16'h0, stall1}, 32'h0);
`endif

    // Two-cycle s_valid gaps between beats
    d1[0] = 20'h13579; d1[1] = 20'h2468A; d1[2] = 20'hFEDCB;
    run_frame(1, 8'd3, 16'h0049, 16'h0000);
    chk("D_lanes", {16'h0, lnz}, 32'h0049);
    chk("D_bubble", {12'h0, cap[1]}, 32'h0);
    chk("D_beat2", {12'h0, cap[3]}, 32'h2468A);
    chk("D_beat3", {12'h0, cap[6]}, 32'hFEDCB);
    chk("D_ready", {16'h0, rdv}, 32'h003F);
    chk("D_psum",  {16'h0, pv},  32'h1240);
    chk("D_done",  {16'h0, fdv}, 32'h2000);
    chk("D_busy",  {16'h0, bzv}, 32'h3FFF);
`ifdef FEEDER_STALL_CNT_EN
    chk("D_stall", {16'h0, stall1}, 32'd4);
`endif

    // start (with a different length) pulsed once in ISSUE and once in DRAIN
    d1[0] = 20'hA1B2C; d1[1] = 20'h3D4E5; d1[2] = 20'h0;
    run_frame(1, 8'd2, 16'h0003, 16'h0012);
    chk("E_lanes", {16'h0, lnz}, 32'h0003);
    chk("E_ready", {16'h0, rdv}, 32'h0001);
    chk("E_psum",  {16'h0, pv},  32'h00C0);
    chk("E_done",  {16'h0, fdv}, 32'h0100);
    chk("E_busy",  {16'h0, bzv}, 32'h01FF);
`ifdef FEEDER_STALL_CNT_EN
    chk("E_stall", {16'h0, stall1}, 32'h0);
`endif

    // Zero-length frame
    start1 = 1'b1; len1 = 8'd0;
    step();
    start1 = 1'b0;
    chk("Z_done",  {31'h0, fd1}, 32'h1);
    chk("Z_busy",  {31'h0, busy1}, 32'h1);
    chk("Z_ready", {31'h0, if1.s_ready}, 32'h0);
    step();
    chk("Z_done_clr", {31'h0, fd1}, 32'h0);
    chk("Z_busy_clr", {31'h0, busy1}, 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      acc = acc | psum1 | if1.s_ready | fd1;
    end
    chk("Z_quiet", {31'h0, acc}, 32'h0);

    // Reset asserted mid-frame, between clock edges
    d1[0] = 20'h55555;
    start1 = 1'b1; len1 = 8'd3; if1.s_valid = 1'b1; if1.s_data = 20'h55555;
    step();
    start1 = 1'b0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("R_lanes", {12'h0, lanes1}, 32'h0);
    chk("R_busy",  {31'h0, busy1}, 32'h0);
    chk("R_ready", {31'h0, if1.s_ready}, 32'h0);
    if1.s_valid = 1'b0;
    step();
    rst = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      acc = acc | psum1 | fd1 | busy1;
    end
    chk("R_after", {31'h0, acc}, 32'h0);
`ifdef FEEDER_STALL_CNT_EN
    chk("R_stall", {16'h0, stall1}, 32'h0);
`endif

    // ISSUE_GAP=3, two beats, s_valid held throughout
    d3[0] = 20'h9ABCD; d3[1] = 20'h1F2E3; d3[2] = 20'h0;
    run_frame(3, 8'd2, 16'h000F, 16'h0000);
    chk("G_lanes", {16'h0, lnz}, 32'h003F);
    chk("G_hold1", {12'h0, cap[2]}, 32'h9ABCD);
    chk("G_beat2", {12'h0, cap[3]}, 32'h1F2E3);
    chk("G_hold2", {12'h0, cap[5]}, 32'h1F2E3);
    chk("G_zero",  {12'h0, cap[6]}, 32'h0);
    chk("G_ready", {16'h0, rdv}, 32'h0004);
    chk("G_psum",  {16'h0, pv},  32'h0240);
    chk("G_done",  {16'h0, fdv}, 32'h1000);
    chk("G_busy",  {16'h0, bzv}, 32'h1FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
